// File: rtl/mem_port_arbiter_if.sv
// Bundle of every pipeline-side and memory-side signal around the shared
// memory port. The arbiter uses the slave view; the pipeline/memory
// environment uses the master view.
interface mem_port_arbiter_if;
  // instruction fetch side
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_req_ready;
  logic [31:0] if_rdata;
  logic        if_rdata_valid;
  logic        if_rdata_ready;
  // data (load/store) side
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_req_ready;
  logic [31:0] d_rdata;
  logic        d_rdata_valid;
  logic        d_rdata_ready;
  // memory side
  logic [31:0] Address;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;
  // status
  logic        arb_err;

  modport slave (
    input  if_req, if_addr, if_rdata_ready,
    input  d_read, d_write, d_addr, d_wdata, d_wstrb, d_rdata_ready,
    input  Mem_Req_Ready, Read_data, Read_data_Valid,
    output if_req_ready, if_rdata, if_rdata_valid,
    output d_req_ready, d_rdata, d_rdata_valid,
    output Address, MemRead, MemWrite, Write_data, Write_strb, Read_data_Ready,
    output arb_err
  );

  modport master (
    output if_req, if_addr, if_rdata_ready,
    output d_read, d_write, d_addr, d_wdata, d_wstrb, d_rdata_ready,
    output Mem_Req_Ready, Read_data, Read_data_Valid,
    input  if_req_ready, if_rdata, if_rdata_valid,
    input  d_req_ready, d_rdata, d_rdata_valid,
    input  Address, MemRead, MemWrite, Write_data, Write_strb, Read_data_Ready,
    input  arb_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory request/response port between instruction fetch and the
// data requester. Data has priority, with a starvation guard that forces IF
// through after STARVE_MAX consecutive data grants. A granted request is held
// (locked) until memory accepts it. Read responses are steered back to their
// issuer using an in-order tag FIFO (tag 0 = IF, tag 1 = data).
module mem_port_arbiter #(
  parameter int OUTSTANDING = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.slave bus
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OUTSTANDING);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);

  typedef enum logic [1:0] {IDLE, LOCK_IF, LOCK_D} state_t;

  state_t           state;
  logic             tag_mem [OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve_cnt;
  logic             err;

  logic read_ok, if_elig, d_elig;
  logic grant_if, grant_d;
  logic mem_read, mem_write, hs, push, pop;
  logic fifo_empty, head_tag;
  logic rd_ready, if_valid, d_valid;

  // Grant selection: free arbitration in IDLE, fixed routing while locked.
  // The FIFO count is the registered one, so a same-cycle pop never frees a
  // slot for a read in that cycle.
  always_comb begin
    read_ok  = (count < CNT_MAX);
    if_elig  = bus.if_req && read_ok;
    d_elig   = bus.d_write || (bus.d_read && read_ok);
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (d_elig && !((starve_cnt == STV_MAX) && if_elig)) grant_d = 1'b1;
          else if (if_elig)                                    grant_if = 1'b1;
        end
        LOCK_IF: grant_if = 1'b1;
        LOCK_D:  grant_d  = 1'b1;
        default: ;
      endcase
    end
    mem_read  = grant_if || (grant_d && bus.d_read);
    mem_write = grant_d && bus.d_write;
    hs        = (mem_read || mem_write) && bus.Mem_Req_Ready;
    push      = hs && mem_read;
  end

  // Response steering by the head tag; an empty FIFO drains stray data.
  always_comb begin
    fifo_empty = (count == '0);
    head_tag   = tag_mem[rd_ptr];
    rd_ready   = 1'b0;
    if_valid   = 1'b0;
    d_valid    = 1'b0;
    if (reset) begin
      if (fifo_empty) begin
        rd_ready = 1'b1;
      end else if (head_tag) begin
        d_valid  = bus.Read_data_Valid;
        rd_ready = bus.d_rdata_ready;
      end else begin
        if_valid = bus.Read_data_Valid;
        rd_ready = bus.if_rdata_ready;
      end
    end
    pop = !fifo_empty && bus.Read_data_Valid && rd_ready;
  end

  assign bus.Address         = grant_if ? bus.if_addr : (grant_d ? bus.d_addr : 32'h0);
  assign bus.MemRead         = mem_read;
  assign bus.MemWrite        = mem_write;
  assign bus.Write_data      = grant_d ? bus.d_wdata : 32'h0;
  assign bus.Write_strb      = grant_d ? bus.d_wstrb : 4'h0;
  assign bus.if_req_ready    = hs && grant_if;
  assign bus.d_req_ready     = hs && grant_d;
  assign bus.if_rdata        = reset ? bus.Read_data : 32'h0;
  assign bus.d_rdata         = reset ? bus.Read_data : 32'h0;
  assign bus.if_rdata_valid  = if_valid;
  assign bus.d_rdata_valid   = d_valid;
  assign bus.Read_data_Ready = rd_ready;
  assign bus.arb_err         = reset ? err : 1'b0;

  // Lock FSM: a grant that memory does not accept is held until it is.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (grant_if && !hs)     state <= LOCK_IF;
          else if (grant_d && !hs) state <= LOCK_D;
        end
        LOCK_IF, LOCK_D: if (hs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tag storage: records which side issued each accepted read.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant_d;
  end

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Starvation counter: data grants taken while IF keeps waiting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!bus.if_req || (hs && grant_if)) begin
      starve_cnt <= '0;
    end else if (hs && grant_d && (starve_cnt != STV_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Sticky error: a response showed up with nothing outstanding.
  always_ff @(posedge clk) begin
    if (!reset) err <= 1'b0;
    else if (fifo_empty && bus.Read_data_Valid) err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven single-cycle vectors,
// hand-written multi-cycle sequences, and a randomized run against a
// queue-based reference model.
module tb_mem_port_arbiter;
  localparam int OUTS = 2;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.OUTSTANDING(OUTS), .STARVE_MAX(SMAX)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int checks = 0;
  int failures = 0;

  typedef logic [139:0] bundle_t;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        mem_ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        if_rr;
    logic        d_rr;
    logic [31:0] e_addr;
    logic        e_mr;
    logic        e_mw;
    logic [31:0] e_wd;
    logic [3:0]  e_ws;
    logic        e_ifr;
    logic        e_dr;
    logic        e_rdr;
    logic        e_ifv;
    logic        e_dv;
  } vec_t;

  vec_t vecs [8];

  function automatic bundle_t mk(logic [31:0] addr, logic mr, logic mw, logic [31:0] wd,
                                 logic [3:0] ws, logic ifr, logic dr, logic [31:0] ifd,
                                 logic ifv, logic [31:0] dd, logic dv, logic rdr, logic err);
    return {addr, mr, mw, wd, ws, ifr, dr, ifd, ifv, dd, dv, rdr, err};
  endfunction

  function automatic bundle_t actual();
    return mk(bus.Address, bus.MemRead, bus.MemWrite, bus.Write_data, bus.Write_strb,
              bus.if_req_ready, bus.d_req_ready, bus.if_rdata, bus.if_rdata_valid,
              bus.d_rdata, bus.d_rdata_valid, bus.Read_data_Ready, bus.arb_err);
  endfunction

  task automatic chk(input string name, input bundle_t act, input bundle_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.if_req = 1'b0;  bus.if_addr = 32'h0;  bus.if_rdata_ready = 1'b0;
    bus.d_read = 1'b0;  bus.d_write = 1'b0;   bus.d_addr = 32'h0;
    bus.d_wdata = 32'h0; bus.d_wstrb = 4'h0;  bus.d_rdata_ready = 1'b0;
    bus.Mem_Req_Ready = 1'b0; bus.Read_data = 32'h0; bus.Read_data_Valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    step();
    reset = 1'b1;
  endtask

  // reference model state for the randomized run
  int q[$];
  int lock_side;
  int starve;
  bit err_m;
  bit if_pend, d_pend, d_is_wr;
  logic [31:0] if_a, d_a, d_wd;
  logic [3:0]  d_ws;

  initial begin
    vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1,
                32'h100, 1'b1, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1,
                32'h104, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h204, 32'hAAAA5555, 4'hF, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1,
                32'h204, 1'b1, 1'b0, 32'hAAAA5555, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h208, 32'h12345678, 4'h3, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1,
                32'h208, 1'b0, 1'b1, 32'h12345678, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h300, 1'b0, 1'b1, 32'h20C, 32'hCAFEF00D, 4'hC, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1,
                32'h20C, 1'b0, 1'b1, 32'hCAFEF00D, 4'hC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h310, 1'b1, 1'b0, 32'h210, 32'h0, 4'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1,
                32'h210, 1'b1, 1'b0, 32'h0, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h5A5A5A5A, 1'b0, 1'b0,
                32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0,
                32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    clear_inputs();
    do_reset();

    // ---------------- table-driven vectors from a fresh reset ----------------
    for (int i = 0; i < 8; i++) begin
      do_reset();
      bus.if_req = vecs[i].if_req;   bus.if_addr = vecs[i].if_addr;
      bus.d_read = vecs[i].d_read;   bus.d_write = vecs[i].d_write;
      bus.d_addr = vecs[i].d_addr;   bus.d_wdata = vecs[i].d_wdata;
      bus.d_wstrb = vecs[i].d_wstrb; bus.Mem_Req_Ready = vecs[i].mem_ready;
      bus.Read_data_Valid = vecs[i].rvalid; bus.Read_data = vecs[i].rdata;
      bus.if_rdata_ready = vecs[i].if_rr;   bus.d_rdata_ready = vecs[i].d_rr;
      @(negedge clk);
      chk($sformatf("vec%0d", i), actual(),
          mk(vecs[i].e_addr, vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_wd, vecs[i].e_ws,
             vecs[i].e_ifr, vecs[i].e_dr, vecs[i].rdata, vecs[i].e_ifv, vecs[i].rdata,
             vecs[i].e_dv, vecs[i].e_rdr, 1'b0));
      $display("vector %0d applied", i);
    end

    // ---------------- IF only, with response ----------------
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.Mem_Req_Ready = 1'b1;
    @(negedge clk);
    chk1("if_only MemRead", bus.MemRead, 1);
    chk1("if_only Address", bus.Address, 32'h100);
    chk1("if_only if_req_ready", bus.if_req_ready, 1);
    step();
    bus.if_req = 1'b0; bus.Read_data_Valid = 1'b1; bus.Read_data = 32'hDEADBEEF;
    bus.if_rdata_ready = 1'b1; bus.d_rdata_ready = 1'b1;
    @(negedge clk);
    chk1("if_only if_rdata_valid", bus.if_rdata_valid, 1);
    chk1("if_only d_rdata_valid", bus.d_rdata_valid, 0);
    chk1("if_only if_rdata", bus.if_rdata, 32'hDEADBEEF);
    step();
    bus.Read_data_Valid = 1'b0;
    @(negedge clk);
    chk1("if_only arb_err", bus.arb_err, 0);
    $display("sequence if_only done");

    // ---------------- collision: data first, then IF ----------------
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.d_read = 1'b1; bus.d_addr = 32'h300; bus.Mem_Req_Ready = 1'b1;
    @(negedge clk);
    chk1("coll c1 Address", bus.Address, 32'h300);
    chk1("coll c1 readies", {bus.if_req_ready, bus.d_req_ready}, 2'b01);
    step();
    bus.d_read = 1'b0;
    @(negedge clk);
    chk1("coll c2 Address", bus.Address, 32'h200);
    chk1("coll c2 readies", {bus.if_req_ready, bus.d_req_ready}, 2'b10);
    step();
    bus.if_req = 1'b0; bus.Read_data_Valid = 1'b1; bus.Read_data = 32'h11;
    bus.if_rdata_ready = 1'b1; bus.d_rdata_ready = 1'b1;
    @(negedge clk);
    chk1("coll r1 valids", {bus.if_rdata_valid, bus.d_rdata_valid}, 2'b01);
    step();
    bus.Read_data = 32'h22;
    @(negedge clk);
    chk1("coll r2 valids", {bus.if_rdata_valid, bus.d_rdata_valid}, 2'b10);
    step();
    bus.Read_data_Valid = 1'b0;
    $display("sequence collision done");

    // ---------------- lock on IF while d_write rises ----------------
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h400; bus.Mem_Req_Ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk1($sformatf("lock stall%0d Address", c), bus.Address, 32'h400);
      chk1($sformatf("lock stall%0d MemWrite", c), bus.MemWrite, 0);
      step();
      bus.d_write = 1'b1; bus.d_addr = 32'h500; bus.d_wdata = 32'h55AA55AA; bus.d_wstrb = 4'hF;
    end
    bus.Mem_Req_Ready = 1'b1;
    @(negedge clk);
    chk1("lock accept Address", bus.Address, 32'h400);
    chk1("lock accept readies", {bus.if_req_ready, bus.d_req_ready}, 2'b10);
    step();
    bus.if_req = 1'b0;
    @(negedge clk);
    chk1("lock after Address", bus.Address, 32'h500);
    chk1("lock after MemWrite", bus.MemWrite, 1);
    chk1("lock after d_req_ready", bus.d_req_ready, 1);
    $display("sequence lock done");

    // ---------------- starvation guard ----------------
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h600;
    bus.d_write = 1'b1; bus.d_addr = 32'h604; bus.d_wdata = 32'h1; bus.d_wstrb = 4'hF;
    bus.Mem_Req_Ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk1($sformatf("starve c%0d readies", c), {bus.if_req_ready, bus.d_req_ready},
           (c == 4) ? 2'b10 : 2'b01);
      step();
      if (c == 4) bus.if_req = 1'b0;
    end
    bus.d_write = 1'b0;
    $display("sequence starvation done");

    // ---------------- full tag FIFO ----------------
    do_reset();
    bus.d_read = 1'b1; bus.d_addr = 32'h700; bus.Mem_Req_Ready = 1'b1;
    bus.d_rdata_ready = 1'b1; bus.if_rdata_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk1($sformatf("full rd%0d accepted", c), {bus.MemRead, bus.d_req_ready}, 2'b11);
      step();
    end
    bus.if_req = 1'b1; bus.if_addr = 32'h800;
    @(negedge clk);
    chk1("full blocked", {bus.MemRead, bus.d_req_ready, bus.if_req_ready}, 3'b000);
    step();
    bus.d_read = 1'b0; bus.d_write = 1'b1; bus.d_wdata = 32'h77; bus.d_wstrb = 4'h1;
    @(negedge clk);
    chk1("full write ok", {bus.MemWrite, bus.d_req_ready, bus.if_req_ready}, 3'b110);
    step();
    bus.d_write = 1'b0; bus.Read_data_Valid = 1'b1; bus.Read_data = 32'h99;
    @(negedge clk);
    chk1("full pop cycle", {bus.MemRead, bus.if_req_ready, bus.d_rdata_valid}, 3'b001);
    step();
    bus.Read_data_Valid = 1'b0;
    @(negedge clk);
    chk1("full read resumes", {bus.MemRead, bus.if_req_ready}, 2'b11);
    chk1("full read Address", bus.Address, 32'h800);
    step();
    bus.if_req = 1'b0;
    $display("sequence full_fifo done");

    // ---------------- stray response and reset ----------------
    do_reset();
    bus.Read_data_Valid = 1'b1; bus.Read_data = 32'h1234;
    @(negedge clk);
    chk1("stray response", {bus.Read_data_Ready, bus.if_rdata_valid, bus.d_rdata_valid, bus.arb_err},
         4'b1000);
    step();
    bus.Read_data_Valid = 1'b0;
    @(negedge clk);
    chk1("stray err set", bus.arb_err, 1);
    step();
    @(negedge clk);
    chk1("stray err held", bus.arb_err, 1);
    step();
    reset = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h900; bus.Mem_Req_Ready = 1'b1;
    bus.Read_data_Valid = 1'b1; bus.Read_data = 32'hFFFF; bus.if_rdata_ready = 1'b1;
    @(negedge clk);
    chk("reset outputs zero", actual(), '0);
    step();
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    chk1("reset clears err", bus.arb_err, 0);
    $display("sequence stray_reset done");

    // ---------------- randomized run against reference model ----------------
    do_reset();
    q.delete(); lock_side = -1; starve = 0; err_m = 1'b0;
    if_pend = 1'b0; d_pend = 1'b0; d_is_wr = 1'b0;
    if_a = '0; d_a = '0; d_wd = '0; d_ws = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit full, ifel, del, mr, mw, hs, empty, ifv, dv, rdr;
      int g;
      logic [31:0] ea, ewd;
      logic [3:0] ews;
      bundle_t exp;

      reset = ($urandom_range(0, 299) != 0);
      bus.if_req = if_pend; bus.if_addr = if_a;
      bus.d_read = d_pend && !d_is_wr; bus.d_write = d_pend && d_is_wr;
      bus.d_addr = d_a; bus.d_wdata = d_wd; bus.d_wstrb = d_ws;
      bus.Mem_Req_Ready = ($urandom_range(0, 3) != 0);
      bus.Read_data_Valid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      bus.Read_data = $urandom;
      bus.if_rdata_ready = ($urandom_range(0, 3) != 0);
      bus.d_rdata_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);

      if (!reset) begin
        chk($sformatf("rand cyc%0d reset", cyc), actual(), '0);
        q.delete(); lock_side = -1; starve = 0; err_m = 1'b0;
      end else begin
        full = (q.size() >= OUTS);
        ifel = bus.if_req && !full;
        del  = bus.d_write || (bus.d_read && !full);
        if (lock_side >= 0)                           g = lock_side;
        else if (del && !(starve == SMAX && ifel))    g = 1;
        else if (ifel)                                g = 0;
        else                                          g = -1;
        mr  = (g == 0) || (g == 1 && bus.d_read);
        mw  = (g == 1) && bus.d_write;
        ea  = (g == 0) ? bus.if_addr : ((g == 1) ? bus.d_addr : 32'h0);
        ewd = (g == 1) ? bus.d_wdata : 32'h0;
        ews = (g == 1) ? bus.d_wstrb : 4'h0;
        hs  = (mr || mw) && bus.Mem_Req_Ready;
        empty = (q.size() == 0);
        ifv = 1'b0; dv = 1'b0; rdr = 1'b1;
        if (!empty) begin
          if (q[0] == 0) begin ifv = bus.Read_data_Valid; rdr = bus.if_rdata_ready; end
          else           begin dv  = bus.Read_data_Valid; rdr = bus.d_rdata_ready;  end
        end
        exp = mk(ea, mr, mw, ewd, ews, hs && g == 0, hs && g == 1, bus.Read_data, ifv,
                 bus.Read_data, dv, rdr, err_m);
        chk($sformatf("rand cyc%0d", cyc), actual(), exp);

        if (!empty && bus.Read_data_Valid && rdr) void'(q.pop_front());
        if (hs && mr) q.push_back(g);
        if (empty && bus.Read_data_Valid) err_m = 1'b1;
        if (!bus.if_req || (hs && g == 0)) starve = 0;
        else if (hs && g == 1 && starve < SMAX) starve++;
        lock_side = hs ? -1 : g;
        if (hs && g == 0) if_pend = 1'b0;
        if (hs && g == 1) d_pend = 1'b0;
      end

      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1'b1; if_a = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_pend && $urandom_range(0, 1) == 0) begin
        d_pend = 1'b1; d_is_wr = $urandom_range(0, 1) == 1;
        d_a = $urandom & 32'hFFFF_FFFC; d_wd = $urandom; d_ws = 4'($urandom_range(0, 15));
      end
      step();
    end
    $display("randomized run done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single memory request/response port between instruction fetch (IF, read-only) and the EX-stage data requester (load/store). It sits between the pipeline stages and the memory interface. It arbitrates requests with data priority and a starvation guard for IF, and holds a granted request until memory accepts it. Read responses are steered back to the requester that issued them through an in-order tag FIFO.

## Interface
- OUTSTANDING, 2, max in-flight reads (tag FIFO depth, ≥1)
- STARVE_MAX, 4, consecutive data grants while IF waits before IF is forced first (≥1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  IF read request
- if_addr  in  32  IF word address
- if_req_ready  out  1  IF request accepted this cycle
- if_rdata  out  32  IF read data
- if_rdata_valid  out  1  IF read data valid
- if_rdata_ready  in  1  IF can take data
- d_read / d_write  in  1 / 1  data read / write request (mutually exclusive)
- d_addr  in  32  data address, word aligned
- d_wdata  in  32  store data
- d_wstrb  in  4  byte strobes
- d_req_ready  out  1  data request accepted this cycle
- d_rdata  out  32  load data
- d_rdata_valid  out  1  load data valid
- d_rdata_ready  in  1  data side can take load data
- Address  out  32  memory request address
- MemRead / MemWrite  out  1 / 1  memory read / write request
- Write_data  out  32  memory write data
- Write_strb  out  4  memory byte strobes
- Mem_Req_Ready  in  1  memory accepts request
- Read_data  in  32  memory read data
- Read_data_Valid  in  1  memory read data valid
- Read_data_Ready  out  1  arbiter accepts read data
- arb_err  out  1  sticky: response arrived with no read outstanding

## Operation
- Requesters hold a request and its fields stable until their req_ready pulses.
- Handshake: a request completes in any cycle where MemRead or MemWrite is high and Mem_Req_Ready is high.
- Eligibility:
  - IF read and data read are eligible only when tag count < OUTSTANDING. The count is taken before any same-cycle pop, so a full FIFO blocks even when a pop happens that cycle.
  - Data write is always eligible.
- FSM states:
  - IDLE: winner chosen combinationally. Eligible data wins unless starve_cnt == STARVE_MAX and IF is eligible, in which case IF wins. The winner drives the memory port in the same cycle. Handshake → stay IDLE. No handshake → LOCK_IF or LOCK_D.
  - LOCK_IF / LOCK_D: only the locked requester is routed, with no re-arbitration. Handshake → IDLE.
- Routing:
  - IF grant: Address=if_addr, MemRead=1, MemWrite=0, Write_data=0, Write_strb=0.
  - Data grant: Address=d_addr, MemRead=d_read, MemWrite=d_write, Write_data=d_wdata, Write_strb=d_wstrb.
  - No grant: all memory outputs are 0.
- if_req_ready / d_req_ready = handshake && grant to that side.
- Tag FIFO:
  - Push on a read handshake: tag 0 = IF, tag 1 = data. Writes push nothing.
  - Head tag steers responses:
    - Read_data is copied to both if_rdata and d_rdata.
    - Only the head side gets rdata_valid = Read_data_Valid.
    - Read_data_Ready = that side's rdata_ready.
  - Pop on Read_data_Valid && Read_data_Ready.
  - Simultaneous push and pop leaves the count unchanged.
- Empty FIFO response: Read_data_Ready=1 (drain), both rdata_valid=0, arb_err set until reset.
- starve_cnt:
  - +1, saturating at STARVE_MAX, on a data handshake while if_req=1.
  - Cleared on an IF handshake or whenever if_req=0.

## Timing
- Zero-cycle request path in IDLE: an accepted request costs one cycle. Each cycle of memory stall adds one cycle in the LOCK state.
- Response path is combinational, with no added latency.
- At most one request handshake per cycle. Back-to-back handshakes are allowed.
- While reset is low, at the next edge: FSM→IDLE, FIFO empty, starve_cnt=0, arb_err=0. While reset is low, all outputs are 0 combinationally, including req_ready, rdata_valid and Read_data_Ready.
- Reset mid-operation drops any lock and all in-flight tags; responses arriving after reset flag arb_err.

## Test plan
- IF only: if_req, addr 0x100, Mem_Req_Ready=1 → MemRead=1 and Address=0x100 in the same cycle, if_req_ready=1. Response 0xDEADBEEF → if_rdata_valid=1, d_rdata_valid=0.
- Collision: if_req and d_read together, Mem_Req_Ready=1 → data granted first, IF granted the next cycle. Responses return in tag order (data, then IF).
- Lock: IF granted with Mem_Req_Ready=0 for 3 cycles while d_write rises → Address stays at IF's address and MemWrite=0 until IF accepts. Data is granted the cycle after.
- Starvation (STARVE_MAX=4): continuous d_write and if_req → exactly 4 data handshakes, then an IF handshake, then data resumes.
- Full FIFO (OUTSTANDING=2): two reads accepted with no response → third read sees MemRead=0, req_ready=0. A d_write is still accepted. After one response pops, the read is accepted the next cycle.
- Stray Read_data_Valid with FIFO empty → Read_data_Ready=1, no rdata_valid, arb_err=1 and held. reset=0 for one edge → arb_err=0 and all outputs 0.
